// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the hazard scoreboard: forwarding encodings,
// the in-flight write slot record and the forward-priority helper.
package hazard_scoreboard_pkg;

  localparam int REG_AW = 5;
  localparam int FWD_W  = 2;

  // EX operand mux encodings
  localparam logic [FWD_W-1:0] FWD_RF    = 2'b00;
  localparam logic [FWD_W-1:0] FWD_EXMEM = 2'b01;
  localparam logic [FWD_W-1:0] FWD_MEMWB = 2'b10;

  // One in-flight register write: valid, destination, and whether the
  // value only exists after the MEM stage
  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] addr;
    logic              ld;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '{v: 1'b0, addr: '0, ld: 1'b0};

  // Youngest producer wins; a WB-slot producer is served by the register
  // file because it writes in the first half of the cycle.
  function automatic logic [FWD_W-1:0] fwd_select(input logic hit_ex,
                                                  input logic hit_mem,
                                                  input logic hit_wb);
    logic [FWD_W-1:0] sel;
    sel = FWD_RF;
    if (hit_ex)
      sel = FWD_EXMEM;
    else if (hit_mem)
      sel = FWD_MEMWB;
    else if (hit_wb)
      sel = FWD_RF;
    return sel;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_match.sv
// Compares one source register against the EX, MEM and WB write slots.
// Register 0 is hard-wired, so it never produces a hit.
module hazard_match
  import hazard_scoreboard_pkg::*;
(
  input  logic [REG_AW-1:0] src,
  input  slot_t             ex_slot,
  input  slot_t             mem_slot,
  input  slot_t             wb_slot,
  output logic              hit_ex,
  output logic              hit_mem,
  output logic              hit_wb,
  output logic              load_hit_ex
);

  logic src_nonzero;

  // Per-slot address match, gated by slot valid and a nonzero source
  always_comb begin
    src_nonzero = (src != '0);
    hit_ex      = src_nonzero && ex_slot.v  && (ex_slot.addr  == src);
    hit_mem     = src_nonzero && mem_slot.v && (mem_slot.addr == src);
    hit_wb      = src_nonzero && wb_slot.v  && (wb_slot.addr  == src);
    load_hit_ex = hit_ex && ex_slot.ld;
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: shadows in-flight register writes in EX/MEM/WB,
// raises the load-use interlock and produces registered forwarding selects
// for the EX operand muxes and the MEM store-data mux.
// Optional feature: define HAZARD_PERF_CNT_EN to add saturating stall and
// forward-issue performance counters.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_AW = hazard_scoreboard_pkg::REG_AW,
  parameter int FWD_W  = hazard_scoreboard_pkg::FWD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rd_rs_ex,
  input  logic              id_rd_rt_ex,
  input  logic              id_rd_rt_mem,
  input  logic              id_wr_en,
  input  logic [REG_AW-1:0] id_wr_addr,
  input  logic              id_is_load,
  input  logic              flush_ex,
  output logic              stall,
  output logic [FWD_W-1:0]  ex_fwd_rs,
  output logic [FWD_W-1:0]  ex_fwd_rt,
  output logic              mem_fwd_st
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_fwd_cnt
`endif
);

  slot_t ex_slot;
  slot_t mem_slot;
  slot_t wb_slot;
  slot_t id_entry;

  logic rs_hit_ex, rs_hit_mem, rs_hit_wb, rs_load_hit_ex;
  logic rt_hit_ex, rt_hit_mem, rt_hit_wb, rt_load_hit_ex;

  logic             issue;
  logic             load_use;
  logic [FWD_W-1:0] sel_rs_next;
  logic [FWD_W-1:0] sel_rt_next;
  logic             st_flag_next;
  logic             ex_st_flag;

  hazard_match u_match_rs (
    .src         (id_rs),
    .ex_slot     (ex_slot),
    .mem_slot    (mem_slot),
    .wb_slot     (wb_slot),
    .hit_ex      (rs_hit_ex),
    .hit_mem     (rs_hit_mem),
    .hit_wb      (rs_hit_wb),
    .load_hit_ex (rs_load_hit_ex)
  );

  hazard_match u_match_rt (
    .src         (id_rt),
    .ex_slot     (ex_slot),
    .mem_slot    (mem_slot),
    .wb_slot     (wb_slot),
    .hit_ex      (rt_hit_ex),
    .hit_mem     (rt_hit_mem),
    .hit_wb      (rt_hit_wb),
    .load_hit_ex (rt_load_hit_ex)
  );

  // Interlock, issue decision and next-cycle forwarding selects for the ID
  // instruction; store-data reads are served later in MEM so never stall
  always_comb begin
    load_use = (id_rd_rs_ex && rs_load_hit_ex) || (id_rd_rt_ex && rt_load_hit_ex);
    stall    = id_valid && !flush_ex && load_use;
    id_ready = !stall;
    issue    = id_valid && !stall && !flush_ex;

    sel_rs_next = FWD_RF;
    sel_rt_next = FWD_RF;
    if (id_rd_rs_ex)
      sel_rs_next = fwd_select(rs_hit_ex, rs_hit_mem, rs_hit_wb);
    if (id_rd_rt_ex)
      sel_rt_next = fwd_select(rt_hit_ex, rt_hit_mem, rt_hit_wb);

    st_flag_next = id_rd_rt_mem && rt_load_hit_ex;

    id_entry      = SLOT_EMPTY;
    id_entry.v    = id_wr_en;
    id_entry.addr = id_wr_addr;
    id_entry.ld   = id_is_load;
  end

  // Advance the write shadow and register the selects into EX (and the
  // store-data flag on into MEM); stalls, flushes and idle cycles insert bubbles
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_slot    <= SLOT_EMPTY;
      mem_slot   <= SLOT_EMPTY;
      wb_slot    <= SLOT_EMPTY;
      ex_fwd_rs  <= FWD_RF;
      ex_fwd_rt  <= FWD_RF;
      ex_st_flag <= 1'b0;
      mem_fwd_st <= 1'b0;
    end else begin
      wb_slot    <= mem_slot;
      mem_slot   <= ex_slot;
      ex_slot    <= issue ? id_entry : SLOT_EMPTY;
      ex_fwd_rs  <= issue ? sel_rs_next : FWD_RF;
      ex_fwd_rt  <= issue ? sel_rt_next : FWD_RF;
      ex_st_flag <= issue && st_flag_next;
      mem_fwd_st <= ex_st_flag;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic fwd_issue;

  // An issue counts as forwarded when any of its selects leaves the regfile path
  always_comb begin
    fwd_issue = issue && ((sel_rs_next != FWD_RF) || (sel_rt_next != FWD_RF) || st_flag_next);
  end

  // Saturating event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_fwd_cnt   <= '0;
    end else begin
      if (stall && (perf_stall_cnt != '1))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (fwd_issue && (perf_fwd_cnt != '1))
        perf_fwd_cnt <= perf_fwd_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: a table of per-cycle ID-stage
// vectors with hand-computed expectations, plus hand-written sequences for
// flush during a load-use stall and reset in mid-stream.
module tb_hazard_scoreboard;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic       id_ready;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_rd_rs_ex;
  logic       id_rd_rt_ex;
  logic       id_rd_rt_mem;
  logic       id_wr_en;
  logic [4:0] id_wr_addr;
  logic       id_is_load;
  logic       flush_ex;
  logic       stall;
  logic [1:0] ex_fwd_rs;
  logic [1:0] ex_fwd_rt;
  logic       mem_fwd_st;

  int checks;
  int errors;

  typedef struct {
    string      name;
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       rrs;
    logic       rrt;
    logic       rrtm;
    logic       wen;
    logic [4:0] waddr;
    logic       ld;
    logic       exp_stall;
    logic [1:0] exp_rs;
    logic [1:0] exp_rt;
    logic       exp_st;
  } vec_t;

  vec_t vecs[$];

  hazard_scoreboard dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_ready     (id_ready),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_rd_rs_ex  (id_rd_rs_ex),
    .id_rd_rt_ex  (id_rd_rt_ex),
    .id_rd_rt_mem (id_rd_rt_mem),
    .id_wr_en     (id_wr_en),
    .id_wr_addr   (id_wr_addr),
    .id_is_load   (id_is_load),
    .flush_ex     (flush_ex),
    .stall        (stall),
    .ex_fwd_rs    (ex_fwd_rs),
    .ex_fwd_rt    (ex_fwd_rt),
    .mem_fwd_st   (mem_fwd_st)
  );

  // Free-running pipeline clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the stimulus ever stalls forever
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  function automatic vec_t mk(input string name, input logic valid,
                              input logic [4:0] rs, input logic [4:0] rt,
                              input logic rrs, input logic rrt, input logic rrtm,
                              input logic wen, input logic [4:0] waddr, input logic ld,
                              input logic e_stall, input logic [1:0] e_rs,
                              input logic [1:0] e_rt, input logic e_st);
    vec_t v;
    v.name = name; v.valid = valid; v.rs = rs; v.rt = rt;
    v.rrs = rrs; v.rrt = rrt; v.rrtm = rrtm;
    v.wen = wen; v.waddr = waddr; v.ld = ld;
    v.exp_stall = e_stall; v.exp_rs = e_rs; v.exp_rt = e_rt; v.exp_st = e_st;
    return v;
  endfunction

  function automatic vec_t nop(input string name, input logic [1:0] e_rs,
                               input logic [1:0] e_rt, input logic e_st);
    return mk(name, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e_rs, e_rt, e_st);
  endfunction

  task automatic applyStimulus(input vec_t v);
    id_valid     = v.valid;
    id_rs        = v.rs;
    id_rt        = v.rt;
    id_rd_rs_ex  = v.rrs;
    id_rd_rt_ex  = v.rrt;
    id_rd_rt_mem = v.rrtm;
    id_wr_en     = v.wen;
    id_wr_addr   = v.waddr;
    id_is_load   = v.ld;
  endtask

  task automatic checkOutput(input string tag, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic checkAll(input vec_t v);
    checkOutput({v.name, "/stall"}, {1'b0, stall}, {1'b0, v.exp_stall});
    checkOutput({v.name, "/id_ready"}, {1'b0, id_ready}, {1'b0, !v.exp_stall});
    checkOutput({v.name, "/ex_fwd_rs"}, ex_fwd_rs, v.exp_rs);
    checkOutput({v.name, "/ex_fwd_rt"}, ex_fwd_rt, v.exp_rt);
    checkOutput({v.name, "/mem_fwd_st"}, {1'b0, mem_fwd_st}, {1'b0, v.exp_st});
  endtask

  task automatic stepRow(input vec_t v);
    @(negedge clk);
    applyStimulus(v);
    #1;
    checkAll(v);
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Each row is one cycle; registered expectations reflect earlier rows
    vecs.push_back(mk("alu_wr3", 1, 1, 2, 1, 1, 0, 1, 3, 0, 0, 0, 0, 0));
    vecs.push_back(mk("alu_rd3", 1, 3, 2, 1, 1, 0, 1, 8, 0, 0, 0, 0, 0));
    vecs.push_back(nop("alu_fwd", 1, 0, 0));
    vecs.push_back(nop("alu_clr1", 0, 0, 0));
    vecs.push_back(nop("alu_clr2", 0, 0, 0));
    vecs.push_back(nop("alu_clr3", 0, 0, 0));
    vecs.push_back(mk("d2_wr5", 1, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0));
    vecs.push_back(nop("d2_gap", 0, 0, 0));
    vecs.push_back(mk("d2_rd5", 1, 0, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(nop("d2_fwd", 0, 2, 0));
    vecs.push_back(mk("d3_wr5", 1, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0));
    vecs.push_back(nop("d3_gap1", 0, 0, 0));
    vecs.push_back(nop("d3_gap2", 0, 0, 0));
    vecs.push_back(mk("d3_rd5", 1, 0, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(nop("d3_rf", 0, 0, 0));
    vecs.push_back(nop("d3_clr1", 0, 0, 0));
    vecs.push_back(nop("d3_clr2", 0, 0, 0));
    vecs.push_back(mk("lu_lw7", 1, 1, 0, 1, 0, 0, 1, 7, 1, 0, 0, 0, 0));
    vecs.push_back(mk("lu_stall", 1, 7, 0, 1, 0, 0, 1, 9, 0, 1, 0, 0, 0));
    vecs.push_back(mk("lu_issue", 1, 7, 0, 1, 0, 0, 1, 9, 0, 0, 0, 0, 0));
    vecs.push_back(nop("lu_fwd", 2, 0, 0));
    vecs.push_back(nop("lu_clr1", 0, 0, 0));
    vecs.push_back(nop("lu_clr2", 0, 0, 0));
    vecs.push_back(nop("lu_clr3", 0, 0, 0));
    vecs.push_back(mk("ls_lw7", 1, 1, 0, 1, 0, 0, 1, 7, 1, 0, 0, 0, 0));
    vecs.push_back(mk("ls_sw", 1, 2, 7, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(nop("ls_wait", 0, 0, 0));
    vecs.push_back(nop("ls_memfwd", 0, 0, 1));
    vecs.push_back(nop("ls_after", 0, 0, 0));
    vecs.push_back(nop("ls_clr", 0, 0, 0));
    vecs.push_back(mk("r0_lw0", 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk("r0_rd0", 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(nop("r0_sel", 0, 0, 0));
    vecs.push_back(mk("yw_wr4a", 1, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0, 0));
    vecs.push_back(mk("yw_wr4b", 1, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0, 0));
    vecs.push_back(mk("yw_rd4", 1, 4, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(nop("yw_fwd", 1, 0, 0));
    vecs.push_back(nop("yw_clr1", 0, 0, 0));
    vecs.push_back(nop("yw_clr2", 0, 0, 0));
    vecs.push_back(nop("yw_clr3", 0, 0, 0));

    // Reset state
    rst      = 1'b1;
    flush_ex = 1'b0;
    applyStimulus(nop("idle", 0, 0, 0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkAll(nop("reset", 0, 0, 0));

    // Table-driven vectors
    for (int i = 0; i < vecs.size(); i++)
      stepRow(vecs[i]);

    // Flush arriving during a load-use stall
    stepRow(mk("fl_lw7", 1, 1, 0, 1, 0, 0, 1, 7, 1, 0, 0, 0, 0));
    stepRow(mk("fl_stall", 1, 7, 0, 1, 0, 0, 1, 9, 0, 1, 0, 0, 0));
    flush_ex = 1'b1;
    #1;
    checkOutput("fl_flush/stall", {1'b0, stall}, 2'd0);
    checkOutput("fl_flush/id_ready", {1'b0, id_ready}, 2'd1);
    @(negedge clk);
    flush_ex = 1'b0;
    applyStimulus(mk("fl_rd", 1, 9, 7, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    checkAll(mk("fl_rd", 1, 9, 7, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    stepRow(nop("fl_sel", 0, 2, 0));
    stepRow(nop("fl_clr1", 0, 0, 0));
    stepRow(nop("fl_clr2", 0, 0, 0));

    // Reset asserted in mid-stream drops in-flight writes and selects
    stepRow(mk("rs_wr3", 1, 1, 0, 1, 0, 0, 1, 3, 0, 0, 0, 0, 0));
    stepRow(mk("rs_lw3", 1, 3, 0, 1, 0, 0, 1, 3, 1, 0, 0, 0, 0));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(mk("rs_rd3", 1, 3, 0, 1, 0, 0, 1, 10, 0, 0, 0, 0, 0));
    #1;
    checkAll(mk("rs_rd3", 1, 3, 0, 1, 0, 0, 1, 10, 0, 0, 0, 0, 0));
    stepRow(nop("rs_sel", 0, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
